piano_note_scheduler: RTL and testbench

- Sequencer and arbiter for the single piano tone datapath (ROM lookup, then fcw, then NCO).
- Shares that datapath between two note requesters: the UART-fed note FIFO and a one-shot live-key source, using round-robin arbitration at note boundaries.
- Owns note length and tempo, and inserts a silent articulation gap between notes.
- Drives the ROM address and the gated fcw to the NCO.

---
 rtl/piano_note_scheduler.sv | 166 ++++++++++++++++
 tb/tb_piano_note_scheduler.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piano_note_scheduler.sv
// piano_note_scheduler
// Sequencer and round-robin arbiter for the single piano tone datapath
// (ROM lookup -> fcw -> NCO). Two requesters share it: the UART-fed note
// FIFO and a one-shot live-key source. Owns note length / tempo and
// inserts a silent articulation gap after every note.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   tempo_up, tempo_down   one-cycle pulses, halve / double note length
//   stop                   one-cycle pulse, abort the current note
//   fifo_dout, fifo_empty  FIFO read data (valid cycle after pop), empty flag
//   fifo_rd_en             FIFO pop
//   key_valid, key_addr    live-key request and its ROM address
//   key_ready              live-key accept
//   rom_address, rom_data  ROM lookup (combinational ROM)
//   fcw                    gated frequency control word to the NCO
//   busy, last_grant       status: not idle, last winner (0 FIFO, 1 key)
//   note_len               current tempo setting in cycles
//
// state | meaning
// IDLE  | arbitrate between FIFO and live key at a note boundary
// FETCH | FIFO data returning; latch it as the ROM address
// PLAY  | fcw follows the ROM for cur_len cycles
// GAP   | silent articulation gap, GAP_CYCLES long
module piano_note_scheduler #(
    parameter int unsigned CYCLES_PER_SECOND = 125_000_000,
    parameter int unsigned DEFAULT_NOTE_LEN  = CYCLES_PER_SECOND / 5,
    parameter int unsigned MIN_NOTE_LEN      = CYCLES_PER_SECOND / 40,
    parameter int unsigned MAX_NOTE_LEN      = CYCLES_PER_SECOND * 2,
    parameter int unsigned GAP_CYCLES        = CYCLES_PER_SECOND / 100,
    parameter int unsigned LEN_W             = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tempo_up,
    input  logic             tempo_down,
    input  logic             stop,
    input  logic [7:0]       fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic             key_valid,
    input  logic [7:0]       key_addr,
    output logic             key_ready,
    output logic [7:0]       rom_address,
    input  logic [23:0]      rom_data,
    output logic [23:0]      fcw,
    output logic             busy,
    output logic             last_grant,
    output logic [LEN_W-1:0] note_len
);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;
    typedef logic [LEN_W:0]   len_ext_t;
    typedef logic [LEN_W-1:0] len_t;

    localparam len_ext_t MIN_EXT     = len_ext_t'(MIN_NOTE_LEN);
    localparam len_ext_t MAX_EXT     = len_ext_t'(MAX_NOTE_LEN);
    localparam len_t     DEFAULT_LEN = len_t'(DEFAULT_NOTE_LEN);
    localparam len_t     GAP_LAST    = len_t'(GAP_CYCLES - 1);
    localparam bit       HAS_GAP     = (GAP_CYCLES != 0);

    if (MIN_NOTE_LEN > MAX_NOTE_LEN || CYCLES_PER_SECOND == 0) begin : g_param_check
        $error("piano_note_scheduler: MIN_NOTE_LEN exceeds MAX_NOTE_LEN or zero clock rate");
    end

    state_t   state, state_next;
    len_t     cur_len, counter, note_len_next;
    len_ext_t len_half, len_dbl;
    logic     fifo_req, key_req, play_done, gap_done;

    assign fifo_req  = !fifo_empty;
    assign key_req   = key_valid;
    assign play_done = (counter == cur_len - len_t'(1));
    assign gap_done  = (counter == GAP_LAST);

    assign busy = (state != IDLE);
    assign fcw  = (state == PLAY) ? rom_data : 24'd0;

    // Shifts are done one bit wider than the register so doubling near the
    // top of the range clamps instead of wrapping.
    assign len_half = {1'b0, note_len} >> 1;
    assign len_dbl  = {note_len, 1'b0};

    always_comb begin
        note_len_next = note_len;
        if (tempo_up && !tempo_down) begin
            note_len_next = (len_half < MIN_EXT) ? MIN_EXT[LEN_W-1:0] : len_half[LEN_W-1:0];
        end else if (tempo_down && !tempo_up) begin
            note_len_next = (len_dbl > MAX_EXT) ? MAX_EXT[LEN_W-1:0] : len_dbl[LEN_W-1:0];
        end
    end

    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        key_ready  = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the source that did not win last time is served.
                if (!stop) begin
                    if (fifo_req && (!key_req || last_grant)) begin
                        fifo_rd_en = 1'b1;
                        state_next = FETCH;
                    end else if (key_req) begin
                        key_ready  = 1'b1;
                        state_next = PLAY;
                    end
                end
            end
            FETCH: state_next = stop ? IDLE : PLAY;
            PLAY: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (play_done) begin
                    state_next = HAS_GAP ? GAP : IDLE;
                end
            end
            GAP: begin
                if (stop || gap_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_len    <= DEFAULT_LEN;
            cur_len     <= DEFAULT_LEN;
            counter     <= '0;
            rom_address <= 8'd0;
            last_grant  <= 1'b1;
        end else begin
            note_len <= note_len_next;
            if (fifo_rd_en) begin
                last_grant <= 1'b0;
            end
            if (key_ready) begin
                last_grant  <= 1'b1;
                rom_address <= key_addr;
            end
            if (state == FETCH) begin
                rom_address <= fifo_dout;
            end
            // Length is frozen at note start so tempo changes hit the next note.
            if (state_next == PLAY && state != PLAY) begin
                cur_len <= note_len;
                counter <= '0;
            end else if (state_next != state) begin
                counter <= '0;
            end else if (state == PLAY || state == GAP) begin
                counter <= counter + len_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_piano_note_scheduler.sv
module tb_piano_note_scheduler;

    localparam int DEF  = 20;
    localparam int MINL = 5;
    localparam int MAXL = 80;
    localparam int GAPC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tempo_up = 1'b0;
    logic        tempo_down = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  fifo_dout = 8'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic        key_valid = 1'b0;
    logic [7:0]  key_addr = 8'd0;
    logic        key_ready;
    logic [7:0]  rom_address;
    logic [23:0] rom_data;
    logic [23:0] fcw;
    logic        busy;
    logic        last_grant;
    logic [31:0] note_len;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] fq[$];
    logic       pop_req = 1'b0;
    logic       key_acc = 1'b0;

    typedef struct {
        logic [23:0] fcw;
        logic        busy;
        logic        rd;
        logic        kr;
        logic        lg;
    } exp_t;

    piano_note_scheduler #(
        .CYCLES_PER_SECOND(100),
        .DEFAULT_NOTE_LEN (20),
        .MIN_NOTE_LEN     (5),
        .MAX_NOTE_LEN     (80),
        .GAP_CYCLES       (4),
        .LEN_W            (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tempo_up   (tempo_up),
        .tempo_down (tempo_down),
        .stop       (stop),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .key_valid  (key_valid),
        .key_addr   (key_addr),
        .key_ready  (key_ready),
        .rom_address(rom_address),
        .rom_data   (rom_data),
        .fcw        (fcw),
        .busy       (busy),
        .last_grant (last_grant),
        .note_len   (note_len)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_fn(input logic [7:0] a);
        if (a == 8'h10) return 24'h00ABCD;
        return {a, a ^ 8'hA5, ~a};
    endfunction

    assign rom_data = rom_fn(rom_address);

    function automatic int mdl_tempo(input int len, input bit up, input bit dn);
        if (up && !dn) return (len / 2 < MINL) ? MINL : len / 2;
        if (dn && !up) return (len * 2 > MAXL) ? MAXL : len * 2;
        return len;
    endfunction

    // Start of a cycle: clear pulses, service the FIFO pop and key handshake
    // seen in the previous cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        tempo_up   = 1'b0;
        tempo_down = 1'b0;
        stop       = 1'b0;
        if (pop_req && fq.size() > 0) fifo_dout = fq.pop_front();
        pop_req = 1'b0;
        if (key_acc) key_valid = 1'b0;
        key_acc    = 1'b0;
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic settle();
        @(negedge clk);
        pop_req = fifo_rd_en;
        key_acc = key_valid && key_ready;
    endtask

    task automatic push(input logic [7:0] a);
        fq.push_back(a);
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        tempo_up   = 1'b0;
        tempo_down = 1'b0;
        stop       = 1'b0;
        key_valid  = 1'b0;
        fq.delete();
        fifo_empty = 1'b1;
        pop_req    = 1'b0;
        key_acc    = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++; if (fcw !== 24'd0) begin errors++; $display("FAIL reset_fcw: got %h want 000000", fcw); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        vectors++; if (key_ready !== 1'b0) begin errors++; $display("FAIL reset_key_ready: got %b want 0", key_ready); end
        vectors++; if (rom_address !== 8'd0) begin errors++; $display("FAIL reset_rom_address: got %h want 00", rom_address); end
        vectors++; if (note_len !== 32'(DEF)) begin errors++; $display("FAIL reset_note_len: got %0d want %0d", note_len, DEF); end
        vectors++; if (last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant: got %b want 1", last_grant); end
    endtask

    task automatic test_single_fifo();
        logic        e_rd, e_busy;
        logic [23:0] e_fcw;
        do_reset();
        tick(); push(8'h10); settle();
        for (int t = 0; t < 28; t++) begin
            if (t > 0) begin tick(); settle(); end
            e_rd   = (t == 0);
            e_busy = (t >= 1 && t <= 25);
            e_fcw  = (t >= 2 && t <= 21) ? 24'h00ABCD : 24'd0;
            vectors++; if (fifo_rd_en !== e_rd) begin errors++; $display("FAIL single_rd_en t%0d: got %b want %b", t, fifo_rd_en, e_rd); end
            vectors++; if (busy !== e_busy) begin errors++; $display("FAIL single_busy t%0d: got %b want %b", t, busy, e_busy); end
            vectors++; if (fcw !== e_fcw) begin errors++; $display("FAIL single_fcw t%0d: got %h want %h", t, fcw, e_fcw); end
            if (t == 2) begin
                vectors++; if (rom_address !== 8'h10) begin errors++; $display("FAIL single_rom_address: got %h want 10", rom_address); end
            end
        end
    endtask

    task automatic test_arbitration();
        logic [7:0] p_addr[$];
        logic       p_lg[$];
        logic [7:0] want_addr[3];
        logic       want_lg[3];
        int         kr_count = 0;
        int         viol = 0;
        logic       prev_zero = 1'b1;
        want_addr[0] = 8'h01; want_addr[1] = 8'h30; want_addr[2] = 8'h02;
        want_lg[0] = 1'b0; want_lg[1] = 1'b1; want_lg[2] = 1'b0;
        do_reset();
        tick(); push(8'h01); push(8'h02); key_valid = 1'b1; key_addr = 8'h30; settle();
        for (int c = 0; c < 200; c++) begin
            if (c > 0) begin tick(); settle(); end
            if (fifo_rd_en && key_ready) viol++;
            if (fifo_rd_en && fifo_empty) viol++;
            if (key_ready) kr_count++;
            if (fcw != 24'd0 && prev_zero) begin
                p_addr.push_back(rom_address);
                p_lg.push_back(last_grant);
            end
            prev_zero = (fcw == 24'd0);
        end
        vectors++; if (viol != 0) begin errors++; $display("FAIL arb_grant_exclusive: got %0d violations want 0", viol); end
        vectors++; if (kr_count != 1) begin errors++; $display("FAIL arb_key_ready_pulses: got %0d want 1", kr_count); end
        vectors++;
        if (p_addr.size() != 3) begin
            errors++; $display("FAIL arb_note_count: got %0d want 3", p_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++; if (p_addr[i] !== want_addr[i]) begin errors++; $display("FAIL arb_order[%0d]: got %h want %h", i, p_addr[i], want_addr[i]); end
                vectors++; if (p_lg[i] !== want_lg[i]) begin errors++; $display("FAIL arb_last_grant[%0d]: got %b want %b", i, p_lg[i], want_lg[i]); end
            end
        end
    endtask

    task automatic test_tempo();
        int up_exp[3];
        int dn_exp[5];
        int lens[$];
        int run = 0;
        up_exp[0] = 10; up_exp[1] = 5; up_exp[2] = 5;
        dn_exp[0] = 40; dn_exp[1] = 80; dn_exp[2] = 80; dn_exp[3] = 80; dn_exp[4] = 80;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(); tempo_up = 1'b1; settle();
            tick(); settle();
            vectors++; if (note_len !== 32'(up_exp[i])) begin errors++; $display("FAIL tempo_up[%0d]: got %0d want %0d", i, note_len, up_exp[i]); end
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(); tempo_down = 1'b1; settle();
            tick(); settle();
            vectors++; if (note_len !== 32'(dn_exp[i])) begin errors++; $display("FAIL tempo_down[%0d]: got %0d want %0d", i, note_len, dn_exp[i]); end
        end
        do_reset();
        tick(); tempo_up = 1'b1; tempo_down = 1'b1; settle();
        tick(); settle();
        vectors++; if (note_len !== 32'(DEF)) begin errors++; $display("FAIL tempo_both: got %0d want %0d", note_len, DEF); end
        do_reset();
        tick(); push(8'h20); push(8'h21); settle();
        for (int c = 0; c < 150; c++) begin
            if (c > 0) begin
                tick();
                if (c == 7) tempo_up = 1'b1;
                settle();
            end
            if (fcw != 24'd0) run++;
            else if (run > 0) begin lens.push_back(run); run = 0; end
        end
        vectors++;
        if (lens.size() != 2) begin
            errors++; $display("FAIL tempo_mid_note_count: got %0d notes want 2", lens.size());
        end else begin
            vectors++; if (lens[0] != DEF) begin errors++; $display("FAIL tempo_mid_note_cur: got %0d want %0d", lens[0], DEF); end
            vectors++; if (lens[1] != 10) begin errors++; $display("FAIL tempo_mid_note_next: got %0d want 10", lens[1]); end
        end
    endtask

    task automatic test_stop();
        int play41 = 0;
        do_reset();
        tick(); push(8'h40); push(8'h41); push(8'h42); settle();
        for (int t = 0; t <= 40; t++) begin
            if (t > 0) begin
                tick();
                if (t == 9) stop = 1'b1;
                settle();
            end
            if (t == 9) begin
                vectors++; if (fcw !== rom_fn(8'h40)) begin errors++; $display("FAIL stop_pre_fcw: got %h want %h", fcw, rom_fn(8'h40)); end
            end
            if (t == 10) begin
                vectors++; if (fcw !== 24'd0) begin errors++; $display("FAIL stop_fcw: got %h want 000000", fcw); end
                vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_idle: got busy %b want 0", busy); end
                vectors++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL stop_next_grant: got rd_en %b want 1", fifo_rd_en); end
            end
            if (t == 36) begin
                vectors++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL stop_fifo_kept: got rd_en %b want 1", fifo_rd_en); end
            end
            if (fcw == rom_fn(8'h41)) play41++;
        end
        vectors++; if (play41 != DEF) begin errors++; $display("FAIL stop_next_len: got %0d want %0d", play41, DEF); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(); tempo_up = 1'b1; settle();
        tick(); push(8'h50); push(8'h51); settle();
        for (int t = 1; t <= 5; t++) begin tick(); settle(); end
        vectors++; if (fcw !== rom_fn(8'h50)) begin errors++; $display("FAIL arst_pre_fcw: got %h want %h", fcw, rom_fn(8'h50)); end
        @(posedge clk);
        #2;
        key_valid = 1'b1;
        key_addr  = 8'h60;
        rst_n     = 1'b0;
        #1;
        vectors++; if (fcw !== 24'd0) begin errors++; $display("FAIL arst_fcw: got %h want 000000", fcw); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        vectors++; if (note_len !== 32'(DEF)) begin errors++; $display("FAIL arst_note_len: got %0d want %0d", note_len, DEF); end
        rst_n = 1'b1;
        settle();
        vectors++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL arst_first_grant_fifo: got %b want 1", fifo_rd_en); end
        vectors++; if (key_ready !== 1'b0) begin errors++; $display("FAIL arst_first_grant_key: got %b want 0", key_ready); end
    endtask

    task automatic test_key_withdraw();
        int kr_seen = 0;
        int sound = 0;
        do_reset();
        tick(); push(8'h70); settle();
        for (int t = 1; t <= 22; t++) begin tick(); settle(); end
        tick(); key_valid = 1'b1; key_addr = 8'h33; settle();
        vectors++; if (key_ready !== 1'b0) begin errors++; $display("FAIL withdraw_in_gap_ready: got %b want 0", key_ready); end
        vectors++; if (busy !== 1'b1 || fcw !== 24'd0) begin errors++; $display("FAIL withdraw_in_gap_state: got busy %b fcw %h want 1 000000", busy, fcw); end
        tick(); key_valid = 1'b0; settle();
        for (int t = 0; t < 30; t++) begin
            if (key_ready) kr_seen++;
            if (fcw != 24'd0) sound++;
            tick(); settle();
        end
        vectors++; if (kr_seen != 0) begin errors++; $display("FAIL withdraw_key_ready: got %0d pulses want 0", kr_seen); end
        vectors++; if (sound != 0) begin errors++; $display("FAIL withdraw_played: got %0d sounding cycles want 0", sound); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL withdraw_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_random();
        int         mdl_len;
        bit         mdl_last;
        exp_t       eq[$];
        exp_t       e;
        logic [7:0] fpend[$];
        logic [7:0] a;
        bit         kpend, use_key, up, dn;
        int         n, nf, op;
        do_reset();
        mdl_len  = DEF;
        mdl_last = 1'b1;
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                tick();
                op = $urandom_range(0, 2);
                up = (op != 1);
                dn = (op != 0);
                tempo_up = up; tempo_down = dn;
                settle();
                mdl_len = mdl_tempo(mdl_len, up, dn);
            end
            tick(); settle();
            vectors++; if (note_len !== 32'(mdl_len)) begin errors++; $display("FAIL rand_note_len r%0d: got %0d want %0d", r, note_len, mdl_len); end

            nf    = $urandom_range(0, 2);
            kpend = (nf == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            fpend.delete();
            for (int i = 0; i < nf; i++) begin
                a = 8'($urandom_range(0, 255));
                push(a);
                fpend.push_back(a);
            end
            if (kpend) begin
                key_valid = 1'b1;
                key_addr  = 8'($urandom_range(0, 255));
            end
            eq.delete();
            while (fpend.size() > 0 || kpend) begin
                use_key = kpend && (fpend.size() == 0 || mdl_last == 1'b0);
                e.fcw = 24'd0; e.busy = 1'b0; e.rd = !use_key; e.kr = use_key; e.lg = mdl_last;
                eq.push_back(e);
                mdl_last = use_key;
                e.rd = 1'b0; e.kr = 1'b0; e.lg = mdl_last; e.busy = 1'b1;
                if (use_key) begin
                    a = key_addr;
                    kpend = 1'b0;
                end else begin
                    a = fpend.pop_front();
                    eq.push_back(e);
                end
                e.fcw = rom_fn(a);
                for (int i = 0; i < mdl_len; i++) eq.push_back(e);
                e.fcw = 24'd0;
                for (int i = 0; i < GAPC; i++) eq.push_back(e);
            end
            e.fcw = 24'd0; e.busy = 1'b0; e.rd = 1'b0; e.kr = 1'b0; e.lg = mdl_last;
            eq.push_back(e);
            eq.push_back(e);
            settle();
            for (int i = 0; i < eq.size(); i++) begin
                if (i > 0) begin tick(); settle(); end
                vectors++; if (fcw !== eq[i].fcw) begin errors++; $display("FAIL rand_fcw r%0d c%0d: got %h want %h", r, i, fcw, eq[i].fcw); end
                vectors++; if (busy !== eq[i].busy) begin errors++; $display("FAIL rand_busy r%0d c%0d: got %b want %b", r, i, busy, eq[i].busy); end
                vectors++; if (fifo_rd_en !== eq[i].rd) begin errors++; $display("FAIL rand_rd_en r%0d c%0d: got %b want %b", r, i, fifo_rd_en, eq[i].rd); end
                vectors++; if (key_ready !== eq[i].kr) begin errors++; $display("FAIL rand_key_ready r%0d c%0d: got %b want %b", r, i, key_ready, eq[i].kr); end
                vectors++; if (last_grant !== eq[i].lg) begin errors++; $display("FAIL rand_last_grant r%0d c%0d: got %b want %b", r, i, last_grant, eq[i].lg); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_fifo();
        test_arbitration();
        test_tempo();
        test_stop();
        test_async_reset();
        test_key_withdraw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
